bus_uart_tx: RTL

//  Memory-mapped serial output port for the 8-bit CoCC computer, downstream of the data bus.

---
 rtl/bus_uart_tx_if.sv | 23 ++
 rtl/bus_uart_tx.sv | 123 ++++++++++++
 2 files changed

// File: rtl/bus_uart_tx_if.sv
// Bus-side signals of the serial output port: CPU write/status strobes, data bus input and status flags.
// The control unit (master) drives we/oe/in. The port (slave) returns the FIFO and TX status.
interface bus_uart_tx_if #(
    parameter int DATA_W = 8
);
    logic              we;
    logic [DATA_W-1:0] in;
    logic              oe;
    logic              full;
    logic              empty;
    logic              busy;
    logic              overflow;

    modport master (
        output we, in, oe,
        input  full, empty, busy, overflow
    );

    modport slave (
        input  we, in, oe,
        output full, empty, busy, overflow
    );
endinterface

// File: rtl/bus_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: bus writes land in a small FIFO, and an FSM drains it onto tx.
// Handshake: a byte is taken on every rising edge with we=1 if the FIFO has room, or if a pop frees a slot that cycle; otherwise it is dropped and overflow sticks.
module bus_uart_tx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 4,
    parameter int DATA_W       = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    bus_uart_tx_if.slave      bus,
    output logic [DATA_W-1:0] out,
    output logic              tx,
    output logic [1:0]        dbg_state_o
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              overflow_q, overflow_d;
    logic [1:0]        state_q, state_d;
    logic [BW-1:0]     baud_q, baud_d;
    logic [IW-1:0]     bit_idx_q, bit_idx_d;
    logic [DATA_W-1:0] shift_q, shift_d;

    logic full, empty, push, pop, drop, baud_end;

    assign full     = (count_q == CW'(FIFO_DEPTH));
    assign empty    = (count_q == '0);
    assign pop      = (state_q == S_IDLE) && !empty;
    assign push     = bus.we && (!full || pop);
    assign drop     = bus.we && full && !pop;
    assign baud_end = (baud_q == BW'(CLKS_PER_BIT - 1));

    always_comb begin
        wr_ptr_d   = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d   = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d    = count_q;
        if (push && !pop) count_d = count_q + 1'b1;
        if (pop && !push) count_d = count_q - 1'b1;
        overflow_d = overflow_q | drop;
    end

    always_comb begin
        state_d   = state_q;
        baud_d    = baud_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        if (state_q == S_IDLE) begin
            if (pop) begin
                shift_d   = mem_q[rd_ptr_q];
                bit_idx_d = '0;
                baud_d    = '0;
                state_d   = S_START;
            end
        end else if (!baud_end) begin
            baud_d = baud_q + 1'b1;
        end else begin
            baud_d = '0;
            if (state_q == S_START) begin
                bit_idx_d = '0;
                state_d   = S_DATA;
            end else if (state_q == S_DATA) begin
                shift_d = shift_q >> 1;
                if (bit_idx_q == IW'(DATA_W - 1)) state_d = S_STOP;
                else bit_idx_d = bit_idx_q + 1'b1;
            end else begin
                state_d = S_IDLE;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            state_q    <= S_IDLE;
            baud_q     <= '0;
            bit_idx_q  <= '0;
            shift_q    <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            state_q    <= state_d;
            baud_q     <= baud_d;
            bit_idx_q  <= bit_idx_d;
            shift_q    <= shift_d;
        end
    end

    // Storage needs no reset: the count alone decides which entries are live.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= bus.in;
    end

    // tx is decoded from the state register, so an async reset forces it high at once.
    always_comb begin
        tx = 1'b1;
        if (state_q == S_START)     tx = 1'b0;
        else if (state_q == S_DATA) tx = shift_q[0];
    end

    assign bus.full     = full;
    assign bus.empty    = empty;
    assign bus.busy     = (state_q != S_IDLE);
    assign bus.overflow = overflow_q;
    assign dbg_state_o  = state_q;

    assign out = bus.oe ? {{(DATA_W-3){1'b0}}, overflow_q, bus.busy, full} : {DATA_W{1'bz}};
endmodule
